// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM states, 2-bit error codes
// and a small state-decode helper.
package counter_seq_pkg;

    // Error codes as reported on err_code
    localparam logic [1:0] ERR_CODE_NONE    = 2'b00;
    localparam logic [1:0] ERR_CODE_LOAD    = 2'b01;
    localparam logic [1:0] ERR_CODE_STEP    = 2'b10;
    localparam logic [1:0] ERR_CODE_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        SE_NONE    = ERR_CODE_NONE,
        SE_LOAD    = ERR_CODE_LOAD,
        SE_STEP    = ERR_CODE_STEP,
        SE_TIMEOUT = ERR_CODE_TIMEOUT
    } seq_err_t;

    // States in which a sequence is in flight (abortable, busy)
    function automatic logic state_is_busy(input seq_state_t s);
        return (s == ST_LOAD) || (s == ST_COUNT);
    endfunction

endpackage

// File: rtl/counter_seq_chk.sv
// Counter response checker: verifies the load value on the first COUNT
// cycle, the single-step progression on later COUNT cycles, and runs the
// unpaused-COUNT watchdog.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_state         sequencer FSM state
//   i_cnt           counter value fed back from the external counter
//   i_start_val     captured load value
//   i_prev_enb      count enable driven in the previous cycle
//   i_updn          captured direction (1 = up)
//   i_pause         pause input (paused cycles do not feed the watchdog)
//   o_err_code_c    error code of the failing check (combinational)
//   o_fail_c        a check failed this cycle (combinational)
module counter_seq_chk
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  seq_state_t       i_state,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_start_val,
    input  logic             i_prev_enb,
    input  logic             i_updn,
    input  logic             i_pause,
    output seq_err_t         o_err_code_c,
    output logic             o_fail_c
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WIDTH-1:0] r_prev_cnt;
    logic             r_first;
    logic [WD_W-1:0]  r_wdog;
    logic [WIDTH-1:0] w_exp_cnt;
    logic             w_in_count;
    logic             w_wdog_hit;

    // History: previous counter value, first-COUNT marker, watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_cnt <= '0;
            r_first    <= 1'b0;
            r_wdog     <= '0;
        end else begin
            r_prev_cnt <= i_cnt;
            r_first    <= (i_state == ST_LOAD);
            if (i_state != ST_COUNT) begin
                r_wdog <= '0;
            end else if (!i_pause) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
        end
    end

    // Check evaluation; load beats step beats timeout
    always_comb begin
        o_fail_c     = 1'b0;
        o_err_code_c = SE_NONE;
        w_in_count   = (i_state == ST_COUNT);
        w_exp_cnt    = r_prev_cnt;
        if (i_prev_enb) begin
            w_exp_cnt = i_updn ? (r_prev_cnt + WIDTH'(1)) : (r_prev_cnt - WIDTH'(1));
        end
        // this cycle is the TIMEOUT-th unpaused COUNT cycle
        w_wdog_hit = !i_pause && (r_wdog == WD_W'(TIMEOUT - 1));

        if (w_in_count) begin
            if (r_first && (i_cnt != i_start_val)) begin
                o_fail_c     = 1'b1;
                o_err_code_c = SE_LOAD;
            end else if (!r_first && (i_cnt != w_exp_cnt)) begin
                o_fail_c     = 1'b1;
                o_err_code_c = SE_STEP;
            end else if (w_wdog_hit) begin
                o_fail_c     = 1'b1;
                o_err_code_c = SE_TIMEOUT;
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Drives an external up/down counter through a load-then-count sequence
// from start_val to end_val, checking every returned value.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               sequence request (sampled in IDLE only)
//   start_val, end_val  load and terminal values (captured on start)
//   pause               hold the counter
//   abort               drop the sequence in LOAD/COUNT
//   clr_err             leave ERR
//   cnt_in              counter output fed back
//   ld_cnt_             active-low counter load
//   count_enb           counter enable (combinational from cnt_in/pause)
//   updn_cnt            counter direction, 1 = up
//   data_in             counter load data
//   busy, done          in-flight flag, one-cycle completion pulse
//   err_code            00 none, 01 load, 10 step, 11 timeout
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic             pause,
    input  logic             abort,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             ld_cnt_,
    output logic             count_enb,
    output logic             updn_cnt,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [WIDTH-1:0] r_start_val;
    logic [WIDTH-1:0] r_end_val;
    logic             r_updn;
    logic             r_ld_cnt_n;
    logic             r_busy;
    logic             r_done;
    logic             r_prev_enb;
    seq_err_t         r_err_code;
    seq_err_t         w_err_next;
    seq_err_t         w_chk_code;
    logic             w_chk_fail;
    logic             w_capture;
    logic             w_at_end;
    logic             w_count_enb;

    assign w_capture = (r_state == ST_IDLE) && start;
    assign w_at_end  = (cnt_in == r_end_val);
    // Enable must follow cnt_in/pause in the same cycle, so it is decoded, not registered
    assign w_count_enb = (r_state == ST_COUNT) && !pause && !w_at_end;

    counter_seq_chk #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_state     (r_state),
        .i_cnt       (cnt_in),
        .i_start_val (r_start_val),
        .i_prev_enb  (r_prev_enb),
        .i_updn      (r_updn),
        .i_pause     (pause),
        .o_err_code_c(w_chk_code),
        .o_fail_c    (w_chk_fail)
    );

    // Next-state and next error code
    always_comb begin
        w_next     = r_state;
        w_err_next = SE_NONE;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_COUNT;
            ST_COUNT: begin
                if (w_chk_fail) begin
                    w_next = ST_ERR;
                end else if (w_at_end) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_ERR:   if (clr_err) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        // abort overrides every transition of an in-flight sequence
        if (abort && state_is_busy(r_state)) begin
            w_next = ST_IDLE;
        end
        if (w_next == ST_ERR) begin
            w_err_next = (r_state == ST_ERR) ? r_err_code : w_chk_code;
        end
    end

    // State, capture and registered output decode of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_start_val <= '0;
            r_end_val   <= '0;
            r_updn      <= 1'b0;
            r_ld_cnt_n  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_prev_enb  <= 1'b0;
            r_err_code  <= SE_NONE;
        end else begin
            r_state    <= w_next;
            r_ld_cnt_n <= (w_next != ST_LOAD);
            r_busy     <= state_is_busy(w_next);
            r_done     <= (w_next == ST_DONE);
            r_prev_enb <= w_count_enb;
            r_err_code <= w_err_next;
            if (w_capture) begin
                r_start_val <= start_val;
                r_end_val   <= end_val;
                r_updn      <= (end_val >= start_val);
            end
        end
    end

    assign ld_cnt_   = r_ld_cnt_n;
    assign count_enb = w_count_enb;
    assign updn_cnt  = r_updn;
    assign data_in   = r_start_val;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer with a behavioural up/down counter model
// (optionally faulty) closing the loop, and a scoreboard of expected
// sequence outcomes.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] start_val;
    logic [7:0] end_val;
    logic       pause;
    logic       abort;
    logic       clr_err;
    logic [7:0] m_cnt;
    logic       ld_cnt_;
    logic       count_enb;
    logic       updn_cnt;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    // 0 = correct counter, 1 = ignores load (loads 0), 2 = skips 3->5 going up
    int mode;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int cyc;
        int done;
        int err;
        int updn;
        int enb;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    counter_sequencer #(
        .WIDTH  (8),
        .TIMEOUT(20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .start_val(start_val),
        .end_val  (end_val),
        .pause    (pause),
        .abort    (abort),
        .clr_err  (clr_err),
        .cnt_in   (m_cnt),
        .ld_cnt_  (ld_cnt_),
        .count_enb(count_enb),
        .updn_cnt (updn_cnt),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .err_code (err_code)
    );

    // External counter model
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 8'd0;
        end else if (!ld_cnt_) begin
            m_cnt <= (mode == 1) ? 8'd0 : data_in;
        end else if (count_enb) begin
            if (updn_cnt) begin
                m_cnt <= (mode == 2 && m_cnt == 8'd3) ? 8'd5 : m_cnt + 8'd1;
            end else begin
                m_cnt <= m_cnt - 8'd1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] out_vec();
        return {ld_cnt_, count_enb, updn_cnt, busy, done, err_code, data_in};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Runs one sequence; called at 2 time units after an edge with the DUT in IDLE.
    // That cycle is cycle 0. Ends on done, an error code, or busy dropping.
    task automatic run_seq(input string tag, input logic [7:0] sv, input logic [7:0] ev,
                           input int md, input int p_at, input int p_len, input int ab_at,
                           input int e_cyc, input int e_done, input int e_err, input int e_enb);
        exp_t e;
        int   cyc;
        int   enb;
        int   o_cyc;
        int   o_done;
        int   o_err;
        int   o_updn;
        bit   ended;
        e.cyc  = e_cyc;
        e.done = e_done;
        e.err  = e_err;
        e.updn = (ev >= sv) ? 1 : 0;
        e.enb  = e_enb;
        sb_q.push_back(e);

        mode      = md;
        start     = 1'b1;
        start_val = sv;
        end_val   = ev;
        cyc    = 0;
        enb    = 0;
        ended  = 1'b0;
        o_cyc  = -1;
        o_done = 0;
        o_err  = 0;
        o_updn = -1;
        while (!ended && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            pause = (cyc >= p_at) && (cyc < p_at + p_len);
            abort = (cyc == ab_at);
            #1;
            if (cyc == 1) begin
                o_updn = int'(updn_cnt);
                check_eq({tag, "_ld"}, 32'(ld_cnt_), 32'(0));
                check_eq({tag, "_data"}, 32'(data_in), 32'(sv));
            end
            if (pause) begin
                check_eq({tag, "_pause_enb"}, 32'(count_enb), 32'(0));
            end
            if (count_enb) enb++;
            if (done || err_code != 2'b00 || (cyc >= 2 && !busy)) begin
                ended  = 1'b1;
                o_cyc  = cyc;
                o_done = int'(done);
                o_err  = int'(err_code);
            end
        end
        pause = 1'b0;
        abort = 1'b0;

        e = sb_q.pop_front();
        check_eq({tag, "_cycle"}, 32'(o_cyc), 32'(e.cyc));
        check_eq({tag, "_done"}, 32'(o_done), 32'(e.done));
        check_eq({tag, "_err"}, 32'(o_err), 32'(e.err));
        check_eq({tag, "_updn"}, 32'(o_updn), 32'(e.updn));
        check_eq({tag, "_enb_cnt"}, 32'(enb), 32'(e.enb));
        if (o_done != 0) begin
            idle(1);
            check_eq({tag, "_pulse"}, 32'({done, busy}), 32'(0));
        end
    endtask

    // In ERR: the code holds, start is ignored, clr_err returns to IDLE
    task automatic err_hold(input string tag, input logic [1:0] code);
        start = 1'b1;
        idle(2);
        check_eq({tag, "_hold"}, 32'(err_code), 32'(code));
        check_eq({tag, "_err_outs"}, 32'({ld_cnt_, count_enb, busy}), 32'(3'b100));
        start   = 1'b0;
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check_eq({tag, "_clr"}, 32'({busy, err_code}), 32'(0));
    endtask

    initial begin
        bit saw_done;
        rst       = 1'b1;
        start     = 1'b0;
        start_val = 8'd0;
        end_val   = 8'd0;
        pause     = 1'b0;
        abort     = 1'b0;
        clr_err   = 1'b0;
        mode      = 0;

        #2;
        check_eq("reset_outs", 32'(out_vec()), 32'(15'h4000));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);

        run_seq("up_5_9",     8'd5,   8'd9,   0, 0, 0, -1,  7, 1, 0, 4);
        run_seq("down_200",   8'd200, 8'd197, 0, 0, 0, -1,  6, 1, 0, 3);
        run_seq("equal_42",   8'd42,  8'd42,  0, 0, 0, -1,  3, 1, 0, 0);
        run_seq("pause_0_10", 8'd0,   8'd10,  0, 5, 3, -1, 16, 1, 0, 10);

        run_seq("load_err",   8'd8,   8'd12,  1, 0, 0, -1,  3, 0, 1, 1);
        mode = 0;
        err_hold("load_err", 2'b01);

        run_seq("step_err",   8'd0,   8'd8,   2, 0, 0, -1,  7, 0, 2, 5);
        mode = 0;
        err_hold("step_err", 2'b10);

        run_seq("wdog_err",   8'd0,   8'd200, 0, 0, 0, -1, 22, 0, 3, 20);
        err_hold("wdog_err", 2'b11);

        run_seq("abort",      8'd0,   8'd10,  0, 0, 0,  4,  5, 0, 0, 3);
        saw_done = 1'b0;
        repeat (4) begin
            idle(1);
            if (done) saw_done = 1'b1;
        end
        check_eq("abort_no_done", 32'(saw_done), 32'(0));

        // Asynchronous reset in the middle of COUNT
        start     = 1'b1;
        start_val = 8'd0;
        end_val   = 8'd10;
        idle(1);
        start = 1'b0;
        idle(3);
        check_eq("pre_rst_busy", 32'({busy, count_enb}), 32'(2'b11));
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_outs", 32'(out_vec()), 32'(15'h4000));
        @(posedge clk);
        #2;
        check_eq("rst_held_outs", 32'(out_vec()), 32'(15'h4000));
        rst = 1'b0;
        idle(1);
        run_seq("after_rst",  8'd5,   8'd9,   0, 0, 0, -1,  7, 1, 0, 4);

        check_eq("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
